// File: rtl/dmem_pkg.sv
// Shared definitions for the data-memory arbiter.
//   SIZE_*   : access size encodings (11 is treated as a word access)
//   owner_t  : which port owns the load response that is in flight
//   misalign : 1 when an access of the given size is not naturally aligned
package dmem_pkg;

    localparam logic [1:0] SIZE_BYTE = 2'b00;
    localparam logic [1:0] SIZE_HALF = 2'b01;
    localparam logic [1:0] SIZE_WORD = 2'b10;

    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_P0   = 2'd1,
        OWN_P1   = 2'd2
    } owner_t;

    function automatic logic misalign(input logic [1:0] size, input logic [1:0] addr_lo);
        logic bad;
        case (size)
            SIZE_BYTE: bad = 1'b0;
            SIZE_HALF: bad = addr_lo[0];
            default:   bad = (addr_lo != 2'b00);
        endcase
        return bad;
    endfunction

endpackage

// File: rtl/dmem_arb_pick.sv
// Combinational grant selection for the two-port data-memory arbiter.
//   req0, req1  : pending requests (port 0 = CPU, port 1 = debug/DMA)
//   starve_cnt  : consecutive cycles port 1 has lost to port 0
//   grant       : one-hot grant, bit 0 = port 0, bit 1 = port 1
module dmem_arb_pick
    import dmem_pkg::*;
#(
    parameter int STARVE_LIMIT = 4,
    parameter int CNT_W        = 3
) (
    input  logic             req0,
    input  logic             req1,
    input  logic [CNT_W-1:0] starve_cnt,
    output logic [1:0]       grant
);

    logic starved;

    // ">=" rather than "==" so a corrupted counter can never lock port 1 out.
    assign starved  = (starve_cnt >= CNT_W'(STARVE_LIMIT));

    assign grant[0] = req0 & ~(req1 & starved);
    assign grant[1] = req1 & (~req0 | starved);

endmodule

// File: rtl/dmem_arbiter.sv
// Two-port arbiter in front of a single-port, byte-addressed data memory.
//   clk, rst_n            : clock, asynchronous active-low reset
//   req*/we*/size*/addr*/wdata* : requester access (held until gnt*)
//   gnt*                  : combinational accept, at most one per cycle
//   rvalid*/rdata*/err*   : response one cycle after an accepted load or a
//                           rejected (misaligned) access
//   m_addr/m_we/m_re/m_half/m_byte/m_wdata : memory command, driven from the winner
//   m_rdata               : memory read data, valid the cycle after m_re
module dmem_arbiter
    import dmem_pkg::*;
#(
    parameter int ADDR_W       = 32,
    parameter int STARVE_LIMIT = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req0,
    input  logic              we0,
    input  logic [1:0]        size0,
    input  logic [ADDR_W-1:0] addr0,
    input  logic [31:0]       wdata0,
    input  logic              req1,
    input  logic              we1,
    input  logic [1:0]        size1,
    input  logic [ADDR_W-1:0] addr1,
    input  logic [31:0]       wdata1,
    output logic              gnt0,
    output logic              gnt1,
    output logic              rvalid0,
    output logic              rvalid1,
    output logic [31:0]       rdata0,
    output logic [31:0]       rdata1,
    output logic              err0,
    output logic              err1,
    output logic [ADDR_W-1:0] m_addr,
    output logic              m_we,
    output logic              m_re,
    output logic              m_half,
    output logic              m_byte,
    output logic [31:0]       m_wdata,
    input  logic [31:0]       m_rdata
);

    localparam int CNT_W = $clog2(STARVE_LIMIT + 1);

    logic [CNT_W-1:0]  starve_cnt;
    logic [1:0]        pick;
    owner_t            resp_owner;
    logic [31:0]       rdata0_q;
    logic [31:0]       rdata1_q;

    logic              sel_we;
    logic [1:0]        sel_size;
    logic [ADDR_W-1:0] sel_addr;
    logic [31:0]       sel_wdata;
    logic              any_gnt;
    logic              mis;

    dmem_arb_pick #(
        .STARVE_LIMIT (STARVE_LIMIT),
        .CNT_W        (CNT_W)
    ) u_pick (
        .req0       (req0),
        .req1       (req1),
        .starve_cnt (starve_cnt),
        .grant      (pick)
    );

    // Grants are masked while in reset so the memory sees no command.
    assign gnt0      = pick[0] & rst_n;
    assign gnt1      = pick[1] & rst_n;
    assign any_gnt   = gnt0 | gnt1;

    assign sel_we    = gnt1 ? we1    : we0;
    assign sel_size  = gnt1 ? size1  : size0;
    assign sel_addr  = gnt1 ? addr1  : addr0;
    assign sel_wdata = gnt1 ? wdata1 : wdata0;

    assign mis       = any_gnt & misalign(sel_size, sel_addr[1:0]);

    assign m_addr    = sel_addr;
    assign m_wdata   = sel_wdata;
    assign m_half    = (sel_size == SIZE_HALF);
    assign m_byte    = (sel_size == SIZE_BYTE);
    assign m_we      = any_gnt & ~mis &  sel_we;
    assign m_re      = any_gnt & ~mis & ~sel_we;

    // During the response cycle the memory's registered data is passed straight
    // through; the hold register keeps it visible afterwards.
    assign rdata0    = (resp_owner == OWN_P0) ? m_rdata : rdata0_q;
    assign rdata1    = (resp_owner == OWN_P1) ? m_rdata : rdata1_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            starve_cnt <= '0;
            resp_owner <= OWN_NONE;
            rvalid0    <= 1'b0;
            rvalid1    <= 1'b0;
            err0       <= 1'b0;
            err1       <= 1'b0;
            rdata0_q   <= '0;
            rdata1_q   <= '0;
        end else begin
            if (!req1 || gnt1)
                starve_cnt <= '0;
            else if (gnt0)
                starve_cnt <= starve_cnt + CNT_W'(1);

            rvalid0 <= gnt0 & (mis | ~we0);
            rvalid1 <= gnt1 & (mis | ~we1);
            err0    <= gnt0 & mis;
            err1    <= gnt1 & mis;

            if (gnt0 && !mis && !we0)
                resp_owner <= OWN_P0;
            else if (gnt1 && !mis && !we1)
                resp_owner <= OWN_P1;
            else
                resp_owner <= OWN_NONE;

            // A new error response supersedes the load data being presented now.
            if (gnt0 && mis)
                rdata0_q <= '0;
            else if (resp_owner == OWN_P0)
                rdata0_q <= m_rdata;

            if (gnt1 && mis)
                rdata1_q <= '0;
            else if (resp_owner == OWN_P1)
                rdata1_q <= m_rdata;
        end
    end

endmodule
